poly_coeff_regbank: RTL

- Parametrised bank of DEPTH GF(2^SYM_W) coefficient registers holding one polynomial, e.g. a remainder or locator polynomial, in the RS Euclidean datapath.
- Generalises the single-symbol load/hold feedback register with:
  - a serial valid/ready fill,
  - shift-up and shift-down by x (polynomial multiply/divide by x),
  - a clear mode,
  - live degree and zero-polynomial tracking.
- Sits between the syndrome/symbol stream and the Euclidean iteration control.

---
 rtl/poly_coeff_regbank_if.sv | 42 ++++
 rtl/poly_coeff_regbank.sv | 124 ++++++++++++
 2 files changed

// File: rtl/poly_coeff_regbank_if.sv
// Bus bundle for poly_coeff_regbank: serial coefficient fill, mode control
// and the coefficient/degree status returned by the bank.
// Optional: POLY_REGBANK_ROTATE_EN adds the rot control line.
interface poly_coeff_regbank_if #(
  parameter int SYM_W = 8,
  parameter int DEPTH = 17,
  parameter int IDX_W = 5
);
  logic                   start;
  logic [SYM_W-1:0]       din;
  logic                   din_valid;
  logic                   din_ready;
  logic                   mode_en;
  logic [1:0]             mode;
`ifdef POLY_REGBANK_ROTATE_EN
  logic                   rot;
`endif
  logic [DEPTH*SYM_W-1:0] coef_out;
  logic                   load_done;
  logic [IDX_W-1:0]       deg;
  logic                   is_zero;

`ifdef POLY_REGBANK_ROTATE_EN
  modport master (
    output start, din, din_valid, mode_en, mode, rot,
    input  din_ready, coef_out, load_done, deg, is_zero
  );
  modport slave (
    input  start, din, din_valid, mode_en, mode, rot,
    output din_ready, coef_out, load_done, deg, is_zero
  );
`else
  modport master (
    output start, din, din_valid, mode_en, mode,
    input  din_ready, coef_out, load_done, deg, is_zero
  );
  modport slave (
    input  start, din, din_valid, mode_en, mode,
    output din_ready, coef_out, load_done, deg, is_zero
  );
`endif
endinterface

// File: rtl/poly_coeff_regbank.sv
// Bank of DEPTH GF(2^SYM_W) coefficient registers holding one polynomial.
// Filled serially (coef[0] first), then shifted by x / cleared on command.
// Degree and zero-polynomial status are derived from the registered bank.
// Optional: POLY_REGBANK_ROTATE_EN turns shifts into cyclic rotates when rot=1.
module poly_coeff_regbank #(
  parameter int SYM_W = 8,
  parameter int DEPTH = 17,
  parameter int IDX_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  poly_coeff_regbank_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             load_done_q, load_done_d;
  logic [SYM_W-1:0] coef_q [DEPTH];
  logic [SYM_W-1:0] coef_d [DEPTH];
  logic             rot_sel;

`ifdef POLY_REGBANK_ROTATE_EN
  assign rot_sel = bus.rot;
`else
  assign rot_sel = 1'b0;
`endif

  // State, write pointer, done pulse and coefficient registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      load_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) coef_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      load_done_q <= load_done_d;
      for (int i = 0; i < DEPTH; i++) coef_q[i] <= coef_d[i];
    end
  end

  // Next-state logic: start wins over everything, then fill or mode ops
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    load_done_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) coef_d[i] = coef_q[i];

    if (bus.start) begin
      state_d  = FILL;
      wr_ptr_d = '0;
      for (int i = 0; i < DEPTH; i++) coef_d[i] = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (bus.din_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (wr_ptr_q == IDX_W'(i)) coef_d[i] = bus.din;
            end
            if (wr_ptr_q == IDX_W'(DEPTH-1)) begin
              state_d     = ACTIVE;
              wr_ptr_d    = '0;
              load_done_d = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + IDX_W'(1);
            end
          end
        end
        ACTIVE: begin
          if (bus.mode_en) begin
            unique case (bus.mode)
              MODE_UP: begin
                for (int i = 1; i < DEPTH; i++) coef_d[i] = coef_q[i-1];
                coef_d[0] = rot_sel ? coef_q[DEPTH-1] : '0;
              end
              MODE_DOWN: begin
                for (int i = 0; i < DEPTH-1; i++) coef_d[i] = coef_q[i+1];
                coef_d[DEPTH-1] = rot_sel ? coef_q[0] : '0;
              end
              MODE_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) coef_d[i] = '0;
              end
              MODE_HOLD: ;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Degree / zero detect: scanning upward lets the highest nonzero index win
  always_comb begin
    bus.deg     = '0;
    bus.is_zero = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (coef_q[i] != '0) begin
        bus.deg     = IDX_W'(i);
        bus.is_zero = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign bus.coef_out[g*SYM_W +: SYM_W] = coef_q[g];
  end

  assign bus.din_ready = (state_q == FILL);
  assign bus.load_done = load_done_q;

endmodule
